pc_state_reg: RTL
=================

# pc_state_reg

Architectural PC register and processor status state machine for the SEQ datapath. It latches the next-PC value computed by the PC-update stage on each committed instruction and presents the current PC to fetch. It tracks the Y86 status code (AOK/HLT/ADR/INS) and freezes the machine on halt or fault. Optional performance counters report cycles and retired instructions.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset and on restart
- IMEM_BYTES, 1024, instruction memory size in bytes; any next PC ≥ this is an address fault
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- commit  input  1  current instruction has completed all stages this cycle; qualifies every input below
- updated_pc  input  64  next PC from PC-update stage
- icode  input  4  icode of the committing instruction
- imem_error  input  1  fetch hit an invalid address
- instr_valid  input  1  decoded icode/ifun is legal
- dmem_error  input  1  memory stage hit an invalid address
- restart  input  1  single-cycle pulse; leaves any stopped state
- pc  output  64  current PC, drives fetch
- stat  output  3  Y86 status: 1=AOK, 2=HLT, 3=ADR, 4=INS
- running  output  1  high only in RUN; fetch/datapath enable
- cycle_cnt  output  64  cycles spent in RUN (macro-dependent)
- instr_cnt  output  64  retired instructions (macro-dependent)

## Operation
- States: RUN, HALT, FAULT_ADR, FAULT_INS; stat is a direct decode (AOK, HLT, ADR, INS).
- In RUN with commit=1, evaluate in this priority order:
  1. imem_error → FAULT_ADR.
  2. !instr_valid → FAULT_INS.
  3. dmem_error → FAULT_ADR.
  4. icode==4'h0 (halt) → HALT.
  5. updated_pc ≥ IMEM_BYTES → FAULT_ADR.
  6. Otherwise pc←updated_pc and stay in RUN.
- On every transition out of RUN, pc holds the address of the offending instruction (not updated_pc).
- In RUN with commit=0: hold all state.
- In HALT or FAULT_*: commit is ignored and pc holds.
- restart=1 in HALT or FAULT_*: pc←RESET_PC, go to RUN.
- restart=1 in RUN: ignored.
- Comparison against IMEM_BYTES is unsigned, 64-bit.

## Timing
- Reset values: pc=RESET_PC, stat=AOK (1), running=1, cycle_cnt=0, instr_cnt=0.
- Reset has priority over commit and restart in the same cycle.
- Reset mid-instruction discards the commit.
- Latency: updated_pc committed in cycle N appears on pc in cycle N+1. Same for stat/running.
- running drops in the cycle after the terminating commit. The datapath must not issue another commit while running=0; such a commit is ignored.
- cycle_cnt increments every cycle the state is RUN, including the terminating-commit cycle.
- instr_cnt increments on each commit accepted in RUN that ends in RUN or HALT. It does not increment for fault transitions.
- Both counters wrap modulo 2^64.
- restart does not clear the counters; only reset does.

## Configuration
- PC_STATE_PERF_CNT_EN defined: cycle_cnt and instr_cnt are implemented as specified.
- Not defined: counter registers are removed and both outputs are tied to 64'h0. The ports remain present.

## Structure
- y86_pkg holds:
  - the stat encodings (STAT_AOK=3'd1, STAT_HLT=3'd2, STAT_ADR=3'd3, STAT_INS=3'd4);
  - the state enum;
  - the icode constant I_HALT=4'h0.
- Natural sub-module: pc_state_perf_cnt. It holds the two counters and is instantiated under the macro.

## Test plan
- Reset with RESET_PC=64'h100 → pc=0x100, stat=1, running=1. Commit with updated_pc=0x10A, icode=6, all flags clean → next cycle pc=0x10A, instr_cnt=1.
- At pc=0x20, commit with icode=0 → pc stays 0x20, stat=2, running=0. Further commits with updated_pc=0x40 leave pc=0x20.
- Commit with instr_valid=0 and dmem_error=1 simultaneously → stat=4 (INS wins), instr_cnt unchanged.
- Commit with updated_pc=0x400 and IMEM_BYTES=1024 → stat=3, pc holds the old value. Then pulse restart → pc=RESET_PC, stat=1, counters unchanged.
- Reset and commit asserted in the same cycle with updated_pc=0x55 → pc=RESET_PC, counters 0. Run 5 idle RUN cycles → cycle_cnt=5, instr_cnt=0.
- Build without PC_STATE_PERF_CNT_EN and run 10 commits → cycle_cnt=instr_cnt=0, PC sequence identical to the counters-enabled build.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the SEQ control slice.
// Contents: status-code encodings, processor state enum, halt icode constant.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT = 4'h0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_FAULT_ADR = 2'd2,
    ST_FAULT_INS = 2'd3
  } pc_state_e;

endpackage

// File: rtl/pc_state_perf_cnt.sv
// Performance counters for the SEQ PC/status block.
// Ports:
//   clk_i        - system clock
//   rst_i        - synchronous active-high reset, clears both counters
//   run_i        - machine is in RUN this cycle
//   retire_i     - an instruction retires this cycle (ends in RUN or HALT)
//   cycle_cnt_o  - cycles spent in RUN, wraps modulo 2^64
//   instr_cnt_o  - retired instructions, wraps modulo 2^64
module pc_state_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        retire_i,
  output logic [63:0] cycle_cnt_o,
  output logic [63:0] instr_cnt_o
);

  logic [63:0] cycle_cnt_q, cycle_cnt_d;
  logic [63:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (run_i)    cycle_cnt_d = cycle_cnt_q + 64'd1;
    if (retire_i) instr_cnt_d = instr_cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/pc_state_reg.sv
// Architectural PC register and Y86 status state machine for the SEQ datapath.
// Latches the committed next PC, tracks AOK/HLT/ADR/INS, freezes on halt or
// fault until restart.
// Optional feature macro: PC_STATE_PERF_CNT_EN (cycle/instruction counters;
// when undefined both counter outputs are tied to zero).
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   commit          - current instruction completes this cycle
//   updated_pc      - next PC from PC-update stage
//   icode           - icode of committing instruction
//   imem_error      - fetch address invalid
//   instr_valid     - decoded instruction legal
//   dmem_error      - memory-stage address invalid
//   restart         - pulse, leaves HALT/FAULT_* and reloads RESET_PC
//   pc              - current PC to fetch
//   stat            - Y86 status code
//   running         - high only in RUN
//   cycle_cnt       - cycles spent in RUN
//   instr_cnt       - retired instructions
import y86_pkg::*;

module pc_state_reg #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] IMEM_BYTES = 64'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit,
  input  logic [63:0] updated_pc,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic        dmem_error,
  input  logic        restart,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic        running,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instr_cnt
);

  pc_state_e   state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        retire;

  // On any exit from RUN the PC is left pointing at the offending instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (commit) begin
          if (imem_error)                 state_d = ST_FAULT_ADR;
          else if (!instr_valid)          state_d = ST_FAULT_INS;
          else if (dmem_error)            state_d = ST_FAULT_ADR;
          else if (icode == I_HALT) begin
            state_d = ST_HALT;
            retire  = 1'b1;
          end
          else if (updated_pc >= IMEM_BYTES) state_d = ST_FAULT_ADR;
          else begin
            pc_d   = updated_pc;
            retire = 1'b1;
          end
        end
      end
      default: begin
        if (restart) begin
          pc_d    = RESET_PC;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    stat = STAT_AOK;
    unique case (state_q)
      ST_RUN:       stat = STAT_AOK;
      ST_HALT:      stat = STAT_HLT;
      ST_FAULT_ADR: stat = STAT_ADR;
      ST_FAULT_INS: stat = STAT_INS;
      default:      stat = STAT_AOK;
    endcase
  end

  assign pc      = pc_q;
  assign running = (state_q == ST_RUN);

`ifdef PC_STATE_PERF_CNT_EN
  pc_state_perf_cnt u_perf_cnt (
    .clk_i       (clk),
    .rst_i       (reset),
    .run_i       (running),
    .retire_i    (retire),
    .cycle_cnt_o (cycle_cnt),
    .instr_cnt_o (instr_cnt)
  );
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt     = '0;
  assign instr_cnt     = '0;
`endif

endmodule
